// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: op encoding, ROB tags, queue entry layout
// and the operand readiness/wakeup helpers used by the queue.
package alu_issue_queue_pkg;

  localparam int ALU_IQ_DEPTH = 4;
  localparam int ROB_TAG_W    = 4;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    rob_tag_t    dst_tag;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } alu_entry_t;

  typedef struct packed {
    alu_entry_t e;
    logic       rs1_rdy;
    logic       rs2_rdy;
    rob_tag_t   rs1_tag;
    rob_tag_t   rs2_tag;
    logic       valid;
  } alu_iq_entry_t;

  // LUI is immediate-only; every other op reads rs1
  function automatic logic rs1_needed(input alu_entry_t e);
    return e.rs1_used || (e.op != ALU_LUI);
  endfunction

  function automatic logic rs2_needed(input alu_entry_t e);
    return e.rs2_used;
  endfunction

  function automatic logic entry_ready(input alu_iq_entry_t x);
    return x.valid && (!rs1_needed(x.e) || x.rs1_rdy) && (!rs2_needed(x.e) || x.rs2_rdy);
  endfunction

  function automatic alu_iq_entry_t wake(input alu_iq_entry_t x, input logic cdb_valid,
                                         input rob_tag_t tag, input logic [31:0] val);
    alu_iq_entry_t r;
    r = x;
    if (cdb_valid && x.valid && rs1_needed(x.e) && !x.rs1_rdy && (x.rs1_tag == tag)) begin
      r.rs1_rdy   = 1'b1;
      r.e.rs1_val = val;
    end
    if (cdb_valid && x.valid && rs2_needed(x.e) && !x.rs2_rdy && (x.rs2_tag == tag)) begin
      r.rs2_rdy   = 1'b1;
      r.e.rs2_val = val;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_queue_select.sv
// Oldest-first picker: one-hot grant of the lowest set bit of the ready vector.
module alu_iq_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_o,
  output logic             any_ready_o
);

  logic [DEPTH-1:0] seen;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      if (gi == 0) begin : g_first
        assign seen[gi] = 1'b0;
      end else begin : g_rest
        assign seen[gi] = seen[gi-1] | ready_i[gi-1];
      end
      assign grant_o[gi] = ready_i[gi] & ~seen[gi];
    end
  endgenerate

  assign any_ready_o = seen[DEPTH-1] | ready_i[DEPTH-1];

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting, age-ordered reservation station for the single-cycle ALU with
// CDB operand capture (including dispatch-time bypass) and flush.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = ALU_IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic                              disp_valid_i,
  output logic                              disp_ready_o,
  input  logic [$bits(alu_iq_entry_t)-1:0]  disp_data_i,
  input  logic                              cdb_valid_i,
  input  logic [$bits(rob_tag_t)-1:0]       cdb_tag_i,
  input  logic [31:0]                       cdb_val_i,
  output logic                              issue_valid_o,
  input  logic                              issue_ready_i,
  output logic [$bits(alu_entry_t)-1:0]     issue_data_o,
  output logic [CNT_W-1:0]                  count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  alu_iq_entry_t    slot_q [DEPTH];
  alu_iq_entry_t    slot_d [DEPTH];
  alu_iq_entry_t    woken  [DEPTH];
  alu_iq_entry_t    shifted[DEPTH];
  alu_iq_entry_t    new_entry;
  logic [CNT_W-1:0] count_q, count_d, count_post;
  logic [DEPTH-1:0] ready_vec, grant;
  logic             any_ready;
  logic [IDX_W-1:0] sel_idx;
  logic             fire, accept;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
      assign ready_vec[gi] = entry_ready(slot_q[gi]);
      assign woken[gi]     = wake(slot_q[gi], cdb_valid_i, cdb_tag_i, cdb_val_i);
    end
  endgenerate

  alu_iq_select #(.DEPTH(DEPTH)) u_select (
    .ready_i     (ready_vec),
    .grant_o     (grant),
    .any_ready_o (any_ready)
  );

  always_comb begin
    sel_idx      = '0;
    issue_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_idx      = IDX_W'(i);
        issue_data_o = slot_q[i].e;
      end
    end
  end

  assign issue_valid_o = any_ready && !flush_i;
  assign disp_ready_o  = !flush_i && (count_q < CNT_W'(DEPTH));
  assign count_o       = count_q;
  assign fire          = issue_valid_o && issue_ready_i;
  assign accept        = disp_valid_i && disp_ready_o;
  assign count_post    = count_q - CNT_W'(fire);

  // Dispatched operands snoop the same-cycle CDB so a broadcast is never missed
  always_comb begin
    alu_iq_entry_t raw;
    raw       = disp_data_i;
    raw.valid = 1'b1;
    new_entry = wake(raw, cdb_valid_i, cdb_tag_i, cdb_val_i);
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
      if (gi == DEPTH-1) begin : g_top
        assign shifted[gi] = fire ? alu_iq_entry_t'('0) : woken[gi];
      end else begin : g_mid
        assign shifted[gi] = (fire && (IDX_W'(gi) >= sel_idx)) ? woken[gi+1] : woken[gi];
      end
      assign slot_d[gi] = flush_i ? alu_iq_entry_t'('0) :
                          (accept && (count_post == CNT_W'(gi))) ? new_entry : shifted[gi];
    end
  endgenerate

  assign count_d = flush_i ? '0 : count_post + CNT_W'(accept);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Age-ordered reservation station in front of the single-cycle ALU.
- Accepts decoded ALU ops from dispatch and holds them until their source operands are available.
- Captures operand values from the common data bus (CDB).
- Issues the oldest fully-ready entry to the ALU through the ALU's req_valid/req_ready handshake.
- Flush discards all contents.

Parameters:
- DEPTH, 4, number of queue entries (>= 2).
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush (mispredict/exception).
- disp_valid_i  in  1  dispatch offers an entry.
- disp_ready_o  out  1  queue can accept an entry.
- disp_data_i  in  $bits(alu_iq_entry_t)  alu_entry_t payload plus rs1_rdy, rs2_rdy, rs1_tag, rs2_tag.
- cdb_valid_i  in  1  CDB broadcast valid.
- cdb_tag_i  in  $bits(rob_tag_t)  producing ROB tag.
- cdb_val_i  in  32  produced value.
- issue_valid_o  out  1  ALU request valid; drives ALU req_valid_i.
- issue_ready_i  in  1  driven from ALU req_ready_o.
- issue_data_o  out  $bits(alu_entry_t)  ALU request payload.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Reset (async, reset_i high):
  - all entry valid bits 0; count 0.
  - Outputs: issue_valid_o=0, disp_ready_o=1 (0 only while flush_i=1), issue_data_o='0, count_o=0.
- Storage:
  - Compacting queue; slot 0 is the oldest entry, valid slots are contiguous from 0.
- Operand ready rules:
  - An operand counts as ready if its rsX_used=0 (or imm-only), or its rsX_rdy bit is set.
  - rs1 is always treated as used when aluop != LUI.
- Dispatch accept:
  - disp_ready_o = !flush_i && (count < DEPTH).
  - No credit is given for a same-cycle issue.
  - Accept when disp_valid_i && disp_ready_o; the entry is written at the first free slot after compaction.
- Wakeup:
  - Every cycle with cdb_valid_i, each valid entry with an unready operand whose tag equals cdb_tag_i stores cdb_val_i into rsX_val and sets rsX_rdy.
  - Incoming dispatch operands are also compared against the same-cycle CDB and captured on write, so no wakeup is ever lost.
  - Rs1 and rs2 of one entry may both wake on the same broadcast.
- Select:
  - Combinational, from registered state only.
  - Picks the lowest-index valid slot with both operands ready.
  - issue_valid_o = any_ready && !flush_i; issue_data_o = the selected slot (rdy/tag fields stripped).
  - Wakeup-to-issue latency is 1 cycle: an entry woken at edge N may issue in the cycle after edge N.
  - Dispatch-to-issue minimum is 1 cycle.
- Issue fire:
  - Fires on issue_valid_o && issue_ready_i.
  - The selected slot is removed at the edge; all younger slots shift down by one.
- Simultaneous dispatch + issue:
  - count unchanged.
  - The new entry lands at index count-1, after the shift.
- Full queue:
  - disp_ready_o=0 even if an issue fires the same cycle.
- Flush:
  - At the edge where flush_i=1, all valid bits clear and count becomes 0.
  - Dispatch and issue are suppressed that cycle; the CDB is ignored.
- Reset mid-operation:
  - Immediate, asynchronous clear; the same end state as flush.
- Invariants:
  - count_o equals the popcount of valid bits.
  - At most one issue and one dispatch per cycle.

Decomposition:
- Add to buffer_pkgs:
  - alu_iq_entry_t: alu_entry_t fields plus rs1_rdy, rs2_rdy, rs1_tag, rs2_tag, valid.
  - rob_tag_t, if not already present.
  - ALU_IQ_DEPTH default constant.
- Sub-module alu_iq_select: DEPTH-wide ready vector -> priority one-hot select plus any_ready.
- Wakeup compare and compaction stay in the top module.

Test Plan:
- Reset then idle -> issue_valid_o=0, disp_ready_o=1, count_o=0; one ADD with rs1_rdy=rs2_rdy=1 dispatched -> issue_valid_o=1 next cycle, data rs1/rs2 values passed through, count_o returns to 0 after fire.
- Dispatch A (rs2 waits on tag 5), then B (ready) -> B issues first. CDB tag 5, value 0x10 -> A issues the following cycle with rs2_val=0x10.
- Fill 4 entries with issue_ready_i=0 -> disp_ready_o=0, count_o=4. Next cycle raise issue_ready_i with disp_valid_i=1 -> slot 0 issues, no accept, count_o=3.
- Dispatch an entry whose rs1_tag=7 in the same cycle as CDB tag 7, value 0xABCD -> the entry issues next cycle with rs1_val=0xABCD.
- 3 valid entries plus flush_i pulse with disp_valid_i=1 -> issue_valid_o=0 and disp_ready_o=0 during flush; count_o=0 after; the dispatched entry is not stored.
- Assert reset_i asynchronously mid-cycle with 2 entries -> issue_valid_o and count_o drop to 0 before the next edge.
